// File: rtl/load_writeback_if.sv
// Bus bundle for load_writeback: ALU requests, load issue/return, decode
// sources, and the register-file write port with bypass outputs.
interface load_writeback_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              alu_valid_i;
  logic              alu_ready_o;
  logic [ADDR_W-1:0] alu_dest_i;
  logic [DATA_W-1:0] alu_data_i;
  logic              load_issue_i;
  logic              load_ready_o;
  logic [ADDR_W-1:0] load_dest_i;
  logic [2:0]        load_type_i;
  logic [1:0]        load_byte_i;
  logic [DATA_W-1:0] load_old_i;
  logic              mem_rvalid_i;
  logic [DATA_W-1:0] mem_rdata_i;
  logic [ADDR_W-1:0] src1_i;
  logic [ADDR_W-1:0] src2_i;
  logic              hazard_o;
  logic [ADDR_W-1:0] rf_addr_o;
  logic [DATA_W-1:0] rf_data_o;
  logic              rf_we_o;
  logic [1:0]        bypass_valid_o;
  logic [DATA_W-1:0] bypass_data_o;

  modport master (
    output alu_valid_i, alu_dest_i, alu_data_i,
    output load_issue_i, load_dest_i, load_type_i, load_byte_i, load_old_i,
    output mem_rvalid_i, mem_rdata_i, src1_i, src2_i,
    input  alu_ready_o, load_ready_o, hazard_o,
    input  rf_addr_o, rf_data_o, rf_we_o, bypass_valid_o, bypass_data_o
  );

  modport slave (
    input  alu_valid_i, alu_dest_i, alu_data_i,
    input  load_issue_i, load_dest_i, load_type_i, load_byte_i, load_old_i,
    input  mem_rvalid_i, mem_rdata_i, src1_i, src2_i,
    output alu_ready_o, load_ready_o, hazard_o,
    output rf_addr_o, rf_data_o, rf_we_o, bypass_valid_o, bypass_data_o
  );
endinterface

// File: rtl/load_writeback.sv
// Register-file write sequencer merging ALU results and a single outstanding load.
// Optional macro WB_BYPASS_EN enables the same-cycle write/read bypass outputs.
module load_writeback #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic             clk,
  input logic             reset_i,
  load_writeback_if.slave bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]        state_reg;
  logic [ADDR_W-1:0] pend_dest_reg;
  logic [2:0]        pend_type_reg;
  logic [1:0]        pend_byte_reg;
  logic [DATA_W-1:0] pend_old_reg;
  logic              squash_reg;
  logic              hold_valid_reg;
  logic [ADDR_W-1:0] hold_dest_reg;
  logic [DATA_W-1:0] hold_data_reg;
  logic              rf_we_reg;
  logic [ADDR_W-1:0] rf_addr_reg;
  logic [DATA_W-1:0] rf_data_reg;

  logic              alu_acc;
  logic              load_ret;
  logic              dest_match;
  logic              squash_now;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] lwl_mask;
  logic [DATA_W-1:0] load_val;

  assign bus.alu_ready_o  = !hold_valid_reg;
  assign bus.load_ready_o = (state_reg == IDLE);
  assign alu_acc    = bus.alu_valid_i && !hold_valid_reg;
  assign load_ret   = (state_reg == WAIT) && bus.mem_rvalid_i;
  assign dest_match = (bus.alu_dest_i == pend_dest_reg) && (pend_dest_reg != '0);
  // A younger ALU write to the load's target makes the load result dead.
  assign squash_now = squash_reg || (alu_acc && dest_match);

  assign bus.hazard_o = (state_reg == WAIT) && !squash_reg && (pend_dest_reg != '0) &&
                        ((bus.src1_i == pend_dest_reg) || (bus.src2_i == pend_dest_reg));

  assign ld_byte  = 8'(bus.mem_rdata_i >> {pend_byte_reg, 3'b000});
  assign ld_half  = pend_byte_reg[1] ? bus.mem_rdata_i[31:16] : bus.mem_rdata_i[15:0];
  assign lwl_mask = (pend_byte_reg == 2'd3) ? '0
                  : (32'hFFFF_FFFF >> {pend_byte_reg + 2'd1, 3'b000});

  always_comb begin
    load_val = bus.mem_rdata_i;
    case (pend_type_reg)
      3'd0: load_val = {{24{ld_byte[7]}}, ld_byte};
      3'd1: load_val = {24'd0, ld_byte};
      3'd2: load_val = {{16{ld_half[15]}}, ld_half};
      3'd3: load_val = {16'd0, ld_half};
      // ~byte is 3-byte for the 2-bit offset
      3'd5: load_val = (bus.mem_rdata_i << {~pend_byte_reg, 3'b000}) | (pend_old_reg & lwl_mask);
      3'd6: load_val = (bus.mem_rdata_i >> {pend_byte_reg, 3'b000}) |
                       (pend_old_reg & ~(32'hFFFF_FFFF >> {pend_byte_reg, 3'b000}));
      default: load_val = bus.mem_rdata_i;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_i) begin
      state_reg      <= IDLE;
      pend_dest_reg  <= '0;
      pend_type_reg  <= '0;
      pend_byte_reg  <= '0;
      pend_old_reg   <= '0;
      squash_reg     <= 1'b0;
      hold_valid_reg <= 1'b0;
      hold_dest_reg  <= '0;
      hold_data_reg  <= '0;
      rf_we_reg      <= 1'b0;
      rf_addr_reg    <= '0;
      rf_data_reg    <= '0;
    end else begin
      rf_we_reg <= 1'b0;
      if (load_ret) begin
        rf_we_reg   <= !squash_now && (pend_dest_reg != '0);
        rf_addr_reg <= pend_dest_reg;
        rf_data_reg <= load_val;
      end else if (hold_valid_reg) begin
        rf_we_reg   <= (hold_dest_reg != '0);
        rf_addr_reg <= hold_dest_reg;
        rf_data_reg <= hold_data_reg;
      end else if (alu_acc) begin
        rf_we_reg   <= (bus.alu_dest_i != '0);
        rf_addr_reg <= bus.alu_dest_i;
        rf_data_reg <= bus.alu_data_i;
      end

      // Hold only fills when the load return wins the write port.
      if (load_ret && alu_acc) begin
        hold_valid_reg <= 1'b1;
        hold_dest_reg  <= bus.alu_dest_i;
        hold_data_reg  <= bus.alu_data_i;
      end else if (!load_ret && hold_valid_reg) begin
        hold_valid_reg <= 1'b0;
      end

      if (state_reg == IDLE) begin
        if (bus.load_issue_i) begin
          state_reg     <= WAIT;
          pend_dest_reg <= bus.load_dest_i;
          pend_type_reg <= bus.load_type_i;
          pend_byte_reg <= bus.load_byte_i;
          pend_old_reg  <= bus.load_old_i;
          squash_reg    <= 1'b0;
        end
      end else if (bus.mem_rvalid_i) begin
        state_reg  <= IDLE;
        squash_reg <= 1'b0;
      end else if (alu_acc && dest_match) begin
        squash_reg <= 1'b1;
      end
    end
  end

  assign bus.rf_we_o   = rf_we_reg;
  assign bus.rf_addr_o = rf_addr_reg;
  assign bus.rf_data_o = rf_data_reg;

`ifdef WB_BYPASS_EN
  logic [ADDR_W-1:0] src_sel [2];
  logic [1:0]        bypass_valid;
  assign src_sel[0] = bus.src1_i;
  assign src_sel[1] = bus.src2_i;
  for (genvar gi = 0; gi < 2; gi++) begin : g_bypass
    assign bypass_valid[gi] = rf_we_reg && (rf_addr_reg != '0) && (rf_addr_reg == src_sel[gi]);
  end
  assign bus.bypass_valid_o = bypass_valid;
  assign bus.bypass_data_o  = rf_data_reg;
`else
  assign bus.bypass_valid_o = 2'b00;
  assign bus.bypass_data_o  = '0;
`endif
endmodule

// File: tb/tb_load_writeback.sv
// Directed self-checking bench for load_writeback; expected values hand-computed.
module tb_load_writeback;
  logic clk = 1'b0;
  logic reset_i = 1'b0;
  int   total = 0;
  int   bad = 0;

  load_writeback_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  load_writeback #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk     (clk),
    .reset_i (reset_i),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one load, return rdata on the next cycle, check the resulting write.
  task automatic do_load(input string tag, input logic [2:0] ty, input logic [1:0] b,
                         input logic [4:0] dest, input logic [31:0] old,
                         input logic [31:0] rdata, input logic [31:0] exp);
    bus.load_issue_i = 1'b1; bus.load_type_i = ty; bus.load_byte_i = b;
    bus.load_dest_i = dest; bus.load_old_i = old;
    step();
    bus.load_issue_i = 1'b0;
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = rdata;
    step();
    bus.mem_rvalid_i = 1'b0;
    check({tag, "_we"}, 32'(bus.rf_we_o), 32'd1);
    check({tag, "_addr"}, 32'(bus.rf_addr_o), 32'(dest));
    check({tag, "_data"}, bus.rf_data_o, exp);
    $display("load %s type=%0d byte=%0d rdata=%h old=%h -> %h", tag, ty, b, rdata, old, bus.rf_data_o);
  endtask

  logic [2:0]  vt [10];
  logic [1:0]  vb [10];
  logic [31:0] vr [10];
  logic [31:0] ve [10];

  initial begin
    bus.alu_valid_i = 0; bus.alu_dest_i = 0; bus.alu_data_i = 0;
    bus.load_issue_i = 0; bus.load_dest_i = 0; bus.load_type_i = 0;
    bus.load_byte_i = 0; bus.load_old_i = 0; bus.mem_rvalid_i = 0;
    bus.mem_rdata_i = 0; bus.src1_i = 0; bus.src2_i = 0;

    // Reset state
    step(); step();
    check("rst_we", 32'(bus.rf_we_o), 0);
    check("rst_addr", 32'(bus.rf_addr_o), 0);
    check("rst_data", bus.rf_data_o, 0);
    check("rst_hazard", 32'(bus.hazard_o), 0);
    check("rst_load_ready", 32'(bus.load_ready_o), 1);
    check("rst_alu_ready", 32'(bus.alu_ready_o), 1);
    check("rst_bypass", 32'(bus.bypass_valid_o), 0);
    $display("reset: we=%b addr=%0d data=%h", bus.rf_we_o, bus.rf_addr_o, bus.rf_data_o);
    reset_i = 1'b1;

    // Plain ALU write
    bus.alu_valid_i = 1; bus.alu_dest_i = 5; bus.alu_data_i = 32'h1234_5678;
    step();
    bus.alu_valid_i = 0;
    check("alu_we", 32'(bus.rf_we_o), 1);
    check("alu_addr", 32'(bus.rf_addr_o), 5);
    check("alu_data", bus.rf_data_o, 32'h1234_5678);
    check("alu_ready", 32'(bus.alu_ready_o), 1);
    $display("alu write r%0d=%h", bus.rf_addr_o, bus.rf_data_o);
    step();
    check("alu_idle_we", 32'(bus.rf_we_o), 0);

    // Simultaneous load return and ALU request
    bus.load_issue_i = 1; bus.load_type_i = 0; bus.load_byte_i = 2; bus.load_dest_i = 3;
    step();
    bus.load_issue_i = 0;
    check("sim_load_ready_wait", 32'(bus.load_ready_o), 0);
    bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h0080_0000;
    bus.alu_valid_i = 1; bus.alu_dest_i = 4; bus.alu_data_i = 7;
    step();
    bus.mem_rvalid_i = 0; bus.alu_valid_i = 0;
    check("sim_n1_we", 32'(bus.rf_we_o), 1);
    check("sim_n1_addr", 32'(bus.rf_addr_o), 3);
    check("sim_n1_data", bus.rf_data_o, 32'hFFFF_FF80);
    check("sim_n1_alu_ready", 32'(bus.alu_ready_o), 0);
    check("sim_n1_load_ready", 32'(bus.load_ready_o), 1);
    $display("sim N+1 write r%0d=%h", bus.rf_addr_o, bus.rf_data_o);
    step();
    check("sim_n2_we", 32'(bus.rf_we_o), 1);
    check("sim_n2_addr", 32'(bus.rf_addr_o), 4);
    check("sim_n2_data", bus.rf_data_o, 7);
    check("sim_n2_alu_ready", 32'(bus.alu_ready_o), 1);
    $display("sim N+2 write r%0d=%h", bus.rf_addr_o, bus.rf_data_o);

    // Extraction table: type, byte, rdata, expected (old = AABBCCDD)
    vt[0] = 5; vb[0] = 1; vr[0] = 32'h1122_3344; ve[0] = 32'h3344_CCDD;
    vt[1] = 6; vb[1] = 1; vr[1] = 32'h1122_3344; ve[1] = 32'hAA11_2233;
    vt[2] = 5; vb[2] = 3; vr[2] = 32'h1122_3344; ve[2] = 32'h1122_3344;
    vt[3] = 5; vb[3] = 0; vr[3] = 32'h1122_3344; ve[3] = 32'h44BB_CCDD;
    vt[4] = 6; vb[4] = 3; vr[4] = 32'h1122_3344; ve[4] = 32'hAABB_CC11;
    vt[5] = 1; vb[5] = 2; vr[5] = 32'h0080_0000; ve[5] = 32'h0000_0080;
    vt[6] = 2; vb[6] = 2; vr[6] = 32'h8001_0000; ve[6] = 32'hFFFF_8001;
    vt[7] = 3; vb[7] = 0; vr[7] = 32'h1234_F00D; ve[7] = 32'h0000_F00D;
    vt[8] = 4; vb[8] = 1; vr[8] = 32'hDEAD_BEEF; ve[8] = 32'hDEAD_BEEF;
    vt[9] = 7; vb[9] = 3; vr[9] = 32'hCAFE_BABE; ve[9] = 32'hCAFE_BABE;
    for (int i = 0; i < 10; i++)
      do_load($sformatf("ext%0d", i), vt[i], vb[i], 5'(10 + i), 32'hAABB_CCDD, vr[i], ve[i]);

    // Hazard, then WAW squash
    bus.load_issue_i = 1; bus.load_type_i = 4; bus.load_byte_i = 0; bus.load_dest_i = 8;
    step();
    bus.load_issue_i = 0;
    bus.src1_i = 8; #1;
    check("haz_src1", 32'(bus.hazard_o), 1);
    bus.src1_i = 0; bus.src2_i = 8; #1;
    check("haz_src2", 32'(bus.hazard_o), 1);
    bus.src2_i = 0; bus.src1_i = 8;
    bus.alu_valid_i = 1; bus.alu_dest_i = 8; bus.alu_data_i = 1;
    step();
    bus.alu_valid_i = 0;
    check("waw_alu_we", 32'(bus.rf_we_o), 1);
    check("waw_alu_data", bus.rf_data_o, 1);
    check("waw_hazard_clear", 32'(bus.hazard_o), 0);
    bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h0000_DEAD;
    step();
    bus.mem_rvalid_i = 0; bus.src1_i = 0;
    check("waw_load_we", 32'(bus.rf_we_o), 0);
    check("waw_load_ready", 32'(bus.load_ready_o), 1);
    $display("waw: r8 load write suppressed we=%b", bus.rf_we_o);

    // Register 0 via ALU and via load
    bus.alu_valid_i = 1; bus.alu_dest_i = 0; bus.alu_data_i = 32'h5555_5555;
    step();
    bus.alu_valid_i = 0;
    check("r0_alu_we", 32'(bus.rf_we_o), 0);
    bus.load_issue_i = 1; bus.load_type_i = 4; bus.load_dest_i = 0;
    step();
    bus.load_issue_i = 0; #1;
    check("r0_hazard", 32'(bus.hazard_o), 0);
    check("r0_wait", 32'(bus.load_ready_o), 0);
    bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h6666_6666;
    step();
    bus.mem_rvalid_i = 0;
    check("r0_load_we", 32'(bus.rf_we_o), 0);
    $display("r0: no write we=%b", bus.rf_we_o);

    // Reset while a load is outstanding
    bus.load_issue_i = 1; bus.load_type_i = 4; bus.load_dest_i = 12;
    step();
    bus.load_issue_i = 0;
    reset_i = 0;
    step();
    reset_i = 1;
    check("rst_wait_ready", 32'(bus.load_ready_o), 1);
    bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h7777_7777;
    step();
    bus.mem_rvalid_i = 0;
    check("rst_wait_we", 32'(bus.rf_we_o), 0);
    check("rst_wait_idle", 32'(bus.load_ready_o), 1);
    $display("reset mid-wait: we=%b ready=%b", bus.rf_we_o, bus.load_ready_o);

    // Bypass
    bus.alu_valid_i = 1; bus.alu_dest_i = 9; bus.alu_data_i = 32'h0BAD_F00D; bus.src2_i = 9;
    step();
    bus.alu_valid_i = 0;
`ifdef WB_BYPASS_EN
    check("bypass_valid", 32'(bus.bypass_valid_o), 32'd2);
    check("bypass_data", bus.bypass_data_o, 32'h0BAD_F00D);
`else
    check("bypass_valid", 32'(bus.bypass_valid_o), 32'd0);
    check("bypass_data", bus.bypass_data_o, 32'd0);
`endif
    check("bypass_we", 32'(bus.rf_we_o), 1);
    $display("bypass: valid=%b data=%h", bus.bypass_valid_o, bus.bypass_data_o);
    bus.src2_i = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
